// File: rtl/sat_counter.sv
// Free-running up-counter that stops at a programmable maximum.
// Asynchronous active-high clear; at_max is a combinational decode of the count register.
module sat_counter #(
  parameter int          count_width = 8,
  parameter int unsigned count_max   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [count_width-1:0] count,
  output logic                   at_max
);

  // Clamp the requested maximum to what the register can hold, computed in 64 bits so count_width=32 is safe.
  localparam longint unsigned lp_width_max = (64'd1 << count_width) - 64'd1;
  localparam longint unsigned lp_req_max   = 64'(count_max);
  localparam longint unsigned lp_eff_full  = (lp_req_max > lp_width_max) ? lp_width_max : lp_req_max;
  localparam logic [count_width-1:0] lp_eff_max = lp_eff_full[count_width-1:0];

  logic [count_width-1:0] r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_count < lp_eff_max) begin
      r_count <= r_count + count_width'(1);
    end
  end

  assign count  = r_count;
  assign at_max = (r_count == lp_eff_max);

endmodule

// File: tb/tb_sat_counter.sv
// Directed self-checking bench for sat_counter: a vector table for the basic run
// plus hand-written sequences for async clear, saturation, width clamp, zero max and periodic clear.
module tb_sat_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c, rst_d, rst_e;
  logic [3:0]  cnt_a;   // width 4,  max 10
  logic [12:0] cnt_b;   // width 13, max 5000
  logic [2:0]  cnt_c;   // width 3,  max 20 (clamped to 7)
  logic [7:0]  cnt_d;   // width 8,  max 0
  logic [7:0]  cnt_e;   // width 8,  max 100
  logic        max_a, max_b, max_c, max_d, max_e;

  sat_counter #(.count_width(4),  .count_max(10))   u_a (.clk(clk), .reset(rst_a), .count(cnt_a), .at_max(max_a));
  sat_counter #(.count_width(13), .count_max(5000)) u_b (.clk(clk), .reset(rst_b), .count(cnt_b), .at_max(max_b));
  sat_counter #(.count_width(3),  .count_max(20))   u_c (.clk(clk), .reset(rst_c), .count(cnt_c), .at_max(max_c));
  sat_counter #(.count_width(8),  .count_max(0))    u_d (.clk(clk), .reset(rst_d), .count(cnt_d), .at_max(max_d));
  sat_counter #(.count_width(8),  .count_max(100))  u_e (.clk(clk), .reset(rst_e), .count(cnt_e), .at_max(max_e));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        reset;
    int unsigned exp_count;
    logic        exp_at_max;
  } vec_t;

  localparam int N_VEC = 33;
  vec_t vecs[N_VEC];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1; rst_e = 1'b1;

    // Reset held 3 edges, then count 1..10 and hold at 10 for 20 more edges.
    for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 0, 1'b0};
    for (int i = 1; i <= 30; i++)
      vecs[i+2] = '{1'b0, (i < 10) ? i : 10, (i >= 10)};

    #1;
    check("a_async_reset_count", cnt_a, 0);
    check("a_async_reset_at_max", max_a, 0);
    for (int i = 0; i < N_VEC; i++) begin
      rst_a = vecs[i].reset;
      if (i == 3) check("a_count_after_release", cnt_a, 0);
      tick();
      check($sformatf("a_vec%0d_count", i), cnt_a, vecs[i].exp_count);
      check($sformatf("a_vec%0d_at_max", i), max_a, vecs[i].exp_at_max);
    end

    // Asynchronous clear: bring count to 7, pulse reset between edges.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("async_pre_count", cnt_a, 7);
    #1; rst_a = 1'b1;
    #1; check("async_cleared_count", cnt_a, 0);
    #1; rst_a = 1'b0;
    #1; check("async_still_zero", cnt_a, 0);
    tick();
    check("async_restart_count", cnt_a, 1);

    // Saturation at 5000 in a 13-bit counter, then clear and restart.
    rst_b = 1'b0;
    for (int i = 1; i <= 4999; i++) tick();
    check("b_4999_count", cnt_b, 4999);
    check("b_4999_at_max", max_b, 0);
    tick();
    check("b_5000_count", cnt_b, 5000);
    check("b_5000_at_max", max_b, 1);
    for (int i = 0; i < 1000; i++) tick();
    check("b_hold_count", cnt_b, 5000);
    check("b_hold_at_max", max_b, 1);
    rst_b = 1'b1;
    #1;
    check("b_clear_count", cnt_b, 0);
    check("b_clear_at_max", max_b, 0);
    tick();
    check("b_clock_in_reset_count", cnt_b, 0);
    rst_b = 1'b0;
    tick();
    check("b_resume_1", cnt_b, 1);
    tick();
    check("b_resume_2", cnt_b, 2);

    // Width-limited maximum: count_max 20 clamps to 7 and must not wrap.
    rst_c = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("c_step%0d_count", i), cnt_c, i);
      check($sformatf("c_step%0d_at_max", i), max_c, (i == 7));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      check("c_hold_count", cnt_c, 7);
      check("c_hold_at_max", max_c, 1);
    end

    // Zero maximum: at_max high even during reset, count never moves.
    check("d_reset_at_max", max_d, 1);
    check("d_reset_count", cnt_d, 0);
    rst_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("d_count", cnt_d, 0);
      check("d_at_max", max_d, 1);
    end

    // Periodic clear every 4th edge: 0,1,2,3,0,1,2,3,...
    for (int k = 0; k < 16; k++) begin
      rst_e = (k % 4 == 0);
      tick();
      check($sformatf("e_k%0d_count", k), cnt_e, k % 4);
      check($sformatf("e_k%0d_at_max", k), max_e, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
